// File: rtl/rbcp_stream_decoder.sv
// rtl/rbcp_stream_decoder.sv - RBCP request parser, bus strobe sequencer and reply streamer
// Byte-stream in, one RBCP strobe per data byte, reply packet out; all outputs registered.
module rbcp_stream_decoder #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        BUS_CLK,
    input  logic        BUS_RST,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    input  logic        RX_LAST,
    output logic        RX_READY,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    output logic        TX_LAST,
    input  logic        TX_READY,
    output logic        RBCP_ACT,
    output logic [31:0] RBCP_ADDR,
    output logic [7:0]  RBCP_WD,
    output logic        RBCP_WE,
    output logic        RBCP_RE,
    input  logic        RBCP_ACK,
    input  logic [7:0]  RBCP_RD,
    output logic        TIMEOUT_ERR,
    output logic        FORMAT_ERR
);

    typedef enum logic [3:0] {
        S_HDR, S_DROP, S_TX_HDR, S_WR_RX, S_WR_BUS, S_WR_TX, S_RD_BUS, S_RD_TX, S_DRAIN
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [2:0]  hdr_idx_q, hdr_idx_d;
    logic        is_wr_q, is_wr_d;
    logic [7:0]  id_q, id_d;
    logic [7:0]  len_q, len_d;
    logic [31:0] base_q, base_d;
    logic [7:0]  idx_q, idx_d;
    logic        last_seen_q, last_seen_d;
    logic        trunc_q, trunc_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        act_clr_q, act_clr_d;
    logic        rx_ready_q, rx_ready_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        tx_last_q, tx_last_d;
    logic        act_q, act_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  wd_q, wd_d;
    logic        we_q, we_d;
    logic        re_q, re_d;
    logic        tout_err_q, tout_err_d;
    logic        fmt_err_q, fmt_err_d;

    logic        rx_fire, tx_fire, idx_is_last, bad;
    logic [2:0]  hdr_nxt;
    logic [7:0]  hdr_nxt_byte, idx_next;

    assign rx_fire     = RX_VALID & rx_ready_q;
    assign tx_fire     = tx_valid_q & TX_READY;
    assign idx_is_last = (idx_q == len_q - 8'd1);
    assign idx_next    = idx_q + 8'd1;
    assign hdr_nxt     = hdr_idx_q + 3'd1;

    always_comb begin
        case (hdr_nxt)
            3'd1:    hdr_nxt_byte = is_wr_q ? 8'h88 : 8'hC8;
            3'd2:    hdr_nxt_byte = id_q;
            3'd3:    hdr_nxt_byte = len_q;
            3'd4:    hdr_nxt_byte = base_q[31:24];
            3'd5:    hdr_nxt_byte = base_q[23:16];
            3'd6:    hdr_nxt_byte = base_q[15:8];
            3'd7:    hdr_nxt_byte = base_q[7:0];
            default: hdr_nxt_byte = 8'hFF;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        hdr_idx_d   = hdr_idx_q;
        is_wr_d     = is_wr_q;
        id_d        = id_q;
        len_d       = len_q;
        base_d      = base_q;
        idx_d       = idx_q;
        last_seen_d = last_seen_q;
        trunc_d     = trunc_q;
        wait_cnt_d  = wait_cnt_q;
        act_clr_d   = 1'b0;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        tx_last_d   = tx_last_q;
        act_d       = act_clr_q ? 1'b0 : act_q;
        addr_d      = addr_q;
        wd_d        = wd_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        tout_err_d  = tout_err_q;
        fmt_err_d   = fmt_err_q;
        bad         = 1'b0;

        case (state_q)
            S_HDR: if (rx_fire) begin
                case (hdr_idx_q)
                    3'd0: bad = (RX_DATA != 8'hFF);
                    3'd1: begin
                        bad     = (RX_DATA != 8'h80) && (RX_DATA != 8'hC0);
                        is_wr_d = (RX_DATA == 8'h80);
                    end
                    3'd2: id_d = RX_DATA;
                    3'd3: begin
                        bad   = (RX_DATA == 8'h00);
                        len_d = RX_DATA;
                    end
                    default: base_d = {base_q[23:0], RX_DATA};
                endcase
                if (bad) begin
                    fmt_err_d = 1'b1;
                    hdr_idx_d = 3'd0;
                    state_d   = RX_LAST ? S_HDR : S_DROP;
                end else if (hdr_idx_q == 3'd7) begin
                    hdr_idx_d = 3'd0;
                    // A write that ends on its header carries no data at all: treated as truncated header.
                    if (RX_LAST && is_wr_q) begin
                        fmt_err_d = 1'b1;
                    end else begin
                        state_d     = S_TX_HDR;
                        act_d       = 1'b1;
                        tx_valid_d  = 1'b1;
                        tx_data_d   = 8'hFF;
                        tx_last_d   = 1'b0;
                        idx_d       = 8'd0;
                        last_seen_d = RX_LAST;
                        trunc_d     = 1'b0;
                    end
                end else if (RX_LAST) begin
                    fmt_err_d = 1'b1;
                    hdr_idx_d = 3'd0;
                end else begin
                    hdr_idx_d = hdr_nxt;
                end
            end
            S_DROP: if (rx_fire && RX_LAST) state_d = S_HDR;
            S_TX_HDR: if (tx_fire) begin
                if (hdr_idx_q == 3'd7) begin
                    hdr_idx_d  = 3'd0;
                    tx_valid_d = 1'b0;
                    if (is_wr_q) begin
                        state_d = S_WR_RX;
                    end else begin
                        state_d = S_RD_BUS;
                        re_d    = 1'b1;
                        addr_d  = base_q;
                    end
                end else begin
                    hdr_idx_d = hdr_nxt;
                    tx_data_d = hdr_nxt_byte;
                end
            end
            S_WR_RX: if (rx_fire) begin
                state_d     = S_WR_BUS;
                we_d        = 1'b1;
                wd_d        = RX_DATA;
                addr_d      = base_q + {24'h0, idx_q};
                last_seen_d = RX_LAST;
                if (RX_LAST && !idx_is_last) begin
                    trunc_d   = 1'b1;
                    fmt_err_d = 1'b1;
                end
            end
            S_WR_BUS, S_RD_BUS: begin
                // The strobe cycle itself never samples ACK.
                if (we_q || re_q) begin
                    wait_cnt_d = 16'd1;
                end else if (RBCP_ACK || (wait_cnt_q == WAIT_LAST)) begin
                    if (!RBCP_ACK) tout_err_d = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_last_d  = idx_is_last;
                    act_clr_d  = idx_is_last || trunc_q;
                    if (state_q == S_WR_BUS) begin
                        tx_data_d = wd_q;
                        state_d   = S_WR_TX;
                    end else begin
                        tx_data_d = RBCP_ACK ? RBCP_RD : 8'h00;
                        state_d   = S_RD_TX;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            S_WR_TX, S_RD_TX: if (tx_fire) begin
                if (idx_is_last) begin
                    tx_valid_d = 1'b0;
                    tx_last_d  = 1'b0;
                    state_d    = last_seen_q ? S_HDR : S_DRAIN;
                end else begin
                    idx_d = idx_next;
                    if (state_q == S_RD_TX) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_RD_BUS;
                        re_d       = 1'b1;
                        addr_d     = base_q + {24'h0, idx_next};
                    end else if (trunc_q) begin
                        tx_data_d = 8'h00;
                        tx_last_d = (idx_next == len_q - 8'd1);
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = S_WR_RX;
                    end
                end
            end
            S_DRAIN: if (rx_fire) begin
                fmt_err_d = 1'b1;
                if (RX_LAST) state_d = S_HDR;
            end
            default: state_d = S_HDR;
        endcase

        rx_ready_d = (state_d == S_HDR) || (state_d == S_DROP) || (state_d == S_WR_RX) ||
                     ((state_d == S_DRAIN) && !last_seen_d);
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_q     <= S_HDR;
            hdr_idx_q   <= 3'd0;
            is_wr_q     <= 1'b0;
            id_q        <= 8'd0;
            len_q       <= 8'd0;
            base_q      <= 32'd0;
            idx_q       <= 8'd0;
            last_seen_q <= 1'b0;
            trunc_q     <= 1'b0;
            wait_cnt_q  <= 16'd0;
            act_clr_q   <= 1'b0;
            rx_ready_q  <= 1'b0;
            tx_data_q   <= 8'd0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            act_q       <= 1'b0;
            addr_q      <= 32'd0;
            wd_q        <= 8'd0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            tout_err_q  <= 1'b0;
            fmt_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_idx_q   <= hdr_idx_d;
            is_wr_q     <= is_wr_d;
            id_q        <= id_d;
            len_q       <= len_d;
            base_q      <= base_d;
            idx_q       <= idx_d;
            last_seen_q <= last_seen_d;
            trunc_q     <= trunc_d;
            wait_cnt_q  <= wait_cnt_d;
            act_clr_q   <= act_clr_d;
            rx_ready_q  <= rx_ready_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            tx_last_q   <= tx_last_d;
            act_q       <= act_d;
            addr_q      <= addr_d;
            wd_q        <= wd_d;
            we_q        <= we_d;
            re_q        <= re_d;
            tout_err_q  <= tout_err_d;
            fmt_err_q   <= fmt_err_d;
        end
    end

    assign RX_READY    = rx_ready_q;
    assign TX_DATA     = tx_data_q;
    assign TX_VALID    = tx_valid_q;
    assign TX_LAST     = tx_last_q;
    assign RBCP_ACT    = act_q;
    assign RBCP_ADDR   = addr_q;
    assign RBCP_WD     = wd_q;
    assign RBCP_WE     = we_q;
    assign RBCP_RE     = re_q;
    assign TIMEOUT_ERR = tout_err_q;
    assign FORMAT_ERR  = fmt_err_q;

endmodule

// File: tb/tb_rbcp_stream_decoder.sv
// tb/tb_rbcp_stream_decoder.sv - scoreboard bench for rbcp_stream_decoder
module tb_rbcp_stream_decoder;

    logic        BUS_CLK = 1'b0;
    logic        BUS_RST;
    logic [7:0]  RX_DATA;
    logic        RX_VALID, RX_LAST, RX_READY;
    logic [7:0]  TX_DATA;
    logic        TX_VALID, TX_LAST, TX_READY;
    logic        RBCP_ACT, RBCP_WE, RBCP_RE, RBCP_ACK;
    logic [31:0] RBCP_ADDR;
    logic [7:0]  RBCP_WD, RBCP_RD;
    logic        TIMEOUT_ERR, FORMAT_ERR;

    typedef struct packed { logic [7:0] data; logic last; } tx_exp_t;
    typedef struct packed { logic wr; logic [31:0] addr; logic [7:0] wd; } st_exp_t;

    tx_exp_t    tx_q[$];
    st_exp_t    st_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] pkt[$];
    logic [7:0] rep[$];
    int         checks, passed, cyc, strobe_cyc, ack_cnt, ack_delay;
    logic       tx_toggle;

    rbcp_stream_decoder #(.ACK_TIMEOUT(4)) dut (
        .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_LAST(RX_LAST), .RX_READY(RX_READY),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_LAST(TX_LAST), .TX_READY(TX_READY),
        .RBCP_ACT(RBCP_ACT), .RBCP_ADDR(RBCP_ADDR), .RBCP_WD(RBCP_WD),
        .RBCP_WE(RBCP_WE), .RBCP_RE(RBCP_RE), .RBCP_ACK(RBCP_ACK), .RBCP_RD(RBCP_RD),
        .TIMEOUT_ERR(TIMEOUT_ERR), .FORMAT_ERR(FORMAT_ERR)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    task automatic push_reply(input int last_at_end);
        for (int i = 0; i < rep.size(); i++)
            tx_q.push_back({rep[i], 1'((last_at_end != 0) && (i == rep.size() - 1))});
    endtask

    task automatic push_st(input logic wr, input logic [31:0] a, input logic [7:0] d);
        st_q.push_back({wr, a, d});
    endtask

    task automatic send_pkt(input int with_last);
        int  n;
        logic acc, all_acc;
        all_acc = 1'b1;
        for (int i = 0; i < pkt.size(); i++) begin
            RX_DATA  = pkt[i];
            RX_LAST  = (with_last != 0) && (i == pkt.size() - 1);
            RX_VALID = 1'b1;
            n = 0;
            acc = 1'b0;
            while (!acc && n < 60) begin
                @(negedge BUS_CLK);
                acc = RX_READY;
                @(posedge BUS_CLK); #1;
                n++;
            end
            if (!acc) all_acc = 1'b0;
        end
        RX_VALID = 1'b0;
        RX_LAST  = 1'b0;
        checks++;
        if (all_acc !== 1'b1) $display("FAIL rx_accept: got %b expected 1", all_acc);
        else passed++;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((tx_q.size() + st_q.size()) != 0 && n < 200) begin
            @(posedge BUS_CLK);
            n++;
        end
        #1;
        checks++;
        if ((tx_q.size() + st_q.size()) != 0) begin
            $display("FAIL %s_outstanding: got %0d tx %0d strobes left, expected 0 0",
                     name, tx_q.size(), st_q.size());
            tx_q.delete();
            st_q.delete();
        end else passed++;
        repeat (3) @(posedge BUS_CLK);
        #1;
    endtask

    task automatic apply_reset(input int chk);
        BUS_RST  = 1'b1;
        RX_VALID = 1'b0;
        RX_LAST  = 1'b0;
        @(posedge BUS_CLK); #1;
        if (chk != 0) begin
            @(negedge BUS_CLK);
            checks++;
            if ({RX_READY, TX_DATA, TX_VALID, TX_LAST, RBCP_ACT, RBCP_ADDR, RBCP_WD, RBCP_WE,
                 RBCP_RE, TIMEOUT_ERR, FORMAT_ERR} !== '0)
                $display("FAIL reset_hold: outputs not all zero, got rx_ready=%b tx_valid=%b act=%b errs=%b%b",
                         RX_READY, TX_VALID, RBCP_ACT, TIMEOUT_ERR, FORMAT_ERR);
            else passed++;
        end
        @(posedge BUS_CLK); #1;
        BUS_RST = 1'b0;
        if (chk != 0) begin
            @(negedge BUS_CLK);
            checks++;
            if ({RX_READY, TX_DATA, TX_VALID, TX_LAST, RBCP_ACT, RBCP_ADDR, RBCP_WD, RBCP_WE,
                 RBCP_RE, TIMEOUT_ERR, FORMAT_ERR} !== '0)
                $display("FAIL reset_release: outputs not all zero, got rx_ready=%b tx_valid=%b act=%b",
                         RX_READY, TX_VALID, RBCP_ACT);
            else passed++;
            @(posedge BUS_CLK); #1;
            @(negedge BUS_CLK);
            checks++;
            if (RX_READY !== 1'b1) $display("FAIL reset_rx_ready: got %b expected 1", RX_READY);
            else passed++;
        end
        @(posedge BUS_CLK); #1;
    endtask

    task automatic test_reset();
        apply_reset(1);
    endtask

    task automatic test_write();
        ack_delay = 1;
        rep = '{8'hFF, 8'h88, 8'h01, 8'h02, 8'h00, 8'h00, 8'h10, 8'h00, 8'hAA, 8'h55};
        push_reply(1);
        push_st(1'b1, 32'h0000_1000, 8'hAA);
        push_st(1'b1, 32'h0000_1001, 8'h55);
        pkt = '{8'hFF, 8'h80, 8'h01, 8'h02, 8'h00, 8'h00, 8'h10, 8'h00, 8'hAA, 8'h55};
        send_pkt(1);
        wait_idle("write");
        checks++;
        if ({TIMEOUT_ERR, FORMAT_ERR, RBCP_ACT} !== 3'b000)
            $display("FAIL write_flags: got tout=%b fmt=%b act=%b expected 000", TIMEOUT_ERR, FORMAT_ERR, RBCP_ACT);
        else passed++;
    endtask

    task automatic test_read_wrap();
        ack_delay = 1;
        rd_q = '{8'h11, 8'h22, 8'h33};
        rep = '{8'hFF, 8'hC8, 8'h07, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h11, 8'h22, 8'h33};
        push_reply(1);
        push_st(1'b0, 32'hFFFF_FFFF, 8'h00);
        push_st(1'b0, 32'h0000_0000, 8'h00);
        push_st(1'b0, 32'h0000_0001, 8'h00);
        pkt = '{8'hFF, 8'hC0, 8'h07, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_pkt(1);
        wait_idle("read");
        checks++;
        if ({TIMEOUT_ERR, FORMAT_ERR} !== 2'b00)
            $display("FAIL read_flags: got tout=%b fmt=%b expected 00", TIMEOUT_ERR, FORMAT_ERR);
        else passed++;
    endtask

    task automatic test_bad_header();
        pkt = '{8'hFE, 8'h80, 8'h01, 8'h01, 8'h00};
        send_pkt(1);
        repeat (12) @(posedge BUS_CLK);
        #1;
        checks++;
        if (FORMAT_ERR !== 1'b1) $display("FAIL bad_hdr_fmt: got %b expected 1", FORMAT_ERR);
        else passed++;
        ack_delay = 1;
        rd_q = '{8'h5A};
        rep = '{8'hFF, 8'hC8, 8'h09, 8'h01, 8'h00, 8'h00, 8'h00, 8'h40, 8'h5A};
        push_reply(1);
        push_st(1'b0, 32'h0000_0040, 8'h00);
        pkt = '{8'hFF, 8'hC0, 8'h09, 8'h01, 8'h00, 8'h00, 8'h00, 8'h40};
        send_pkt(1);
        wait_idle("after_bad");
    endtask

    task automatic test_timeout();
        int  n;
        logic found;
        apply_reset(1);
        ack_delay = 0;
        rep = '{8'hFF, 8'hC8, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h30, 8'h00};
        push_reply(1);
        push_st(1'b0, 32'h0000_0030, 8'h00);
        pkt = '{8'hFF, 8'hC0, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h30};
        send_pkt(1);
        n = 0;
        found = 1'b0;
        while (!found && n < 40) begin
            @(negedge BUS_CLK); #1;
            found = TIMEOUT_ERR;
            n++;
        end
        checks++;
        if (!found || (cyc - strobe_cyc) != 4)
            $display("FAIL timeout_latency: got found=%b delay=%0d expected found=1 delay=4",
                     found, cyc - strobe_cyc);
        else passed++;
        @(posedge BUS_CLK); #1;
        wait_idle("timeout");
        checks++;
        if ({TIMEOUT_ERR, FORMAT_ERR} !== 2'b10)
            $display("FAIL timeout_flags: got tout=%b fmt=%b expected 10", TIMEOUT_ERR, FORMAT_ERR);
        else passed++;
    endtask

    task automatic test_backpressure_trunc();
        apply_reset(0);
        ack_delay = 1;
        tx_toggle = 1'b1;
        rep = '{8'hFF, 8'h88, 8'h02, 8'h03, 8'h00, 8'h00, 8'h20, 8'h00, 8'hAA, 8'h00, 8'h00};
        push_reply(1);
        push_st(1'b1, 32'h0000_2000, 8'hAA);
        pkt = '{8'hFF, 8'h80, 8'h02, 8'h03, 8'h00, 8'h00, 8'h20, 8'h00, 8'hAA};
        send_pkt(1);
        wait_idle("trunc");
        tx_toggle = 1'b0;
        checks++;
        if ({TIMEOUT_ERR, FORMAT_ERR} !== 2'b01)
            $display("FAIL trunc_flags: got tout=%b fmt=%b expected 01", TIMEOUT_ERR, FORMAT_ERR);
        else passed++;
    endtask

    task automatic test_reset_midpacket();
        int n;
        ack_delay = 1;
        rep = '{8'hFF, 8'h88, 8'h04, 8'h02, 8'h00, 8'h00, 8'h30, 8'h00, 8'hAA};
        push_reply(0);
        push_st(1'b1, 32'h0000_3000, 8'hAA);
        pkt = '{8'hFF, 8'h80, 8'h04, 8'h02, 8'h00, 8'h00, 8'h30, 8'h00, 8'hAA};
        send_pkt(0);
        wait_idle("mid_first");
        ack_delay = 0;
        push_st(1'b1, 32'h0000_3001, 8'h55);
        pkt = '{8'h55};
        send_pkt(1);
        n = 0;
        while (st_q.size() != 0 && n < 20) begin
            @(posedge BUS_CLK);
            n++;
        end
        #1;
        checks++;
        if (st_q.size() != 0) $display("FAIL mid_second_strobe: got %0d pending expected 0", st_q.size());
        else passed++;
        apply_reset(1);
        repeat (10) @(posedge BUS_CLK);
        #1;
        checks++;
        if ({RBCP_ACT, TX_VALID, TIMEOUT_ERR, FORMAT_ERR, RX_READY} !== 5'b00001)
            $display("FAIL mid_after_reset: got act=%b tx_valid=%b tout=%b fmt=%b rx_ready=%b expected 00001",
                     RBCP_ACT, TX_VALID, TIMEOUT_ERR, FORMAT_ERR, RX_READY);
        else passed++;
    endtask

    initial begin
        checks = 0; passed = 0; cyc = 0; strobe_cyc = 0; ack_cnt = 0; ack_delay = 1;
        tx_toggle = 1'b0;
        BUS_RST = 1'b1; RX_DATA = 8'h00; RX_VALID = 1'b0; RX_LAST = 1'b0;
        TX_READY = 1'b1; RBCP_ACK = 1'b0; RBCP_RD = 8'h00;
        fork
            forever begin
                @(posedge BUS_CLK); #1;
                RBCP_ACK = 1'b0;
                if (ack_cnt > 0) begin
                    ack_cnt--;
                    if (ack_cnt == 0) begin
                        RBCP_ACK = 1'b1;
                        RBCP_RD  = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
                    end
                end
                TX_READY = tx_toggle ? ~TX_READY : 1'b1;
                @(negedge BUS_CLK);
                cyc++;
                if (TX_VALID === 1'b1 && TX_READY === 1'b1) begin
                    checks++;
                    if (tx_q.size() == 0) begin
                        $display("FAIL tx_unexpected: got byte %h last %b expected none", TX_DATA, TX_LAST);
                    end else begin
                        tx_exp_t e;
                        e = tx_q.pop_front();
                        if ({TX_DATA, TX_LAST} !== {e.data, e.last})
                            $display("FAIL tx_byte: got %h last %b expected %h last %b",
                                     TX_DATA, TX_LAST, e.data, e.last);
                        else passed++;
                    end
                end
                if (RBCP_WE === 1'b1 || RBCP_RE === 1'b1) begin
                    strobe_cyc = cyc;
                    if (ack_delay > 0) ack_cnt = ack_delay;
                    checks++;
                    if (st_q.size() == 0) begin
                        $display("FAIL strobe_unexpected: got we=%b re=%b addr=%h", RBCP_WE, RBCP_RE, RBCP_ADDR);
                    end else begin
                        st_exp_t s;
                        s = st_q.pop_front();
                        if (RBCP_WE !== s.wr || RBCP_RE !== !s.wr || RBCP_ADDR !== s.addr ||
                            (s.wr && RBCP_WD !== s.wd))
                            $display("FAIL strobe: got we=%b re=%b addr=%h wd=%h expected wr=%b addr=%h wd=%h",
                                     RBCP_WE, RBCP_RE, RBCP_ADDR, RBCP_WD, s.wr, s.addr, s.wd);
                        else passed++;
                    end
                end
            end
        join_none
        @(posedge BUS_CLK); #1;
        test_reset();
        test_write();
        test_read_wrap();
        test_bad_header();
        test_timeout();
        test_backpressure_trunc();
        test_reset_midpacket();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/rbcp_stream_decoder.md
# rbcp_stream_decoder

Byte-stream front end for the RBCP slave-control path. It parses RBCP request packets (SiTCP header format) arriving on a valid/ready byte stream and replays each data byte as a single RBCP write or read strobe toward `rbcp_to_bus`. It streams the matching RBCP reply packet out on a second valid/ready byte stream. The block sits between a UDP/UART byte transport and `rbcp_to_bus`, in the `BUS_CLK` domain.

## Interface
- `ACK_TIMEOUT`, default 255: cycles to wait for `RBCP_ACK` after a strobe. Range 2..65535.
- `BUS_CLK` in 1: single clock. All logic is on the rising edge.
- `BUS_RST` in 1: reset, synchronous and active-high.
- `RX_DATA` in 8: request byte.
- `RX_VALID` in 1: `RX_DATA` is valid.
- `RX_LAST` in 1: marks the final byte of the request packet.
- `RX_READY` out 1: byte accepted when `RX_VALID & RX_READY`.
- `TX_DATA` out 8: reply byte.
- `TX_VALID` out 1: `TX_DATA` is valid.
- `TX_LAST` out 1: marks the final reply byte.
- `TX_READY` in 1: byte consumed when `TX_VALID & TX_READY`.
- `RBCP_ACT` out 1: high while the packet's bus phase is active.
- `RBCP_ADDR` out 32: byte address.
- `RBCP_WD` out 8: write data.
- `RBCP_WE` out 1: one-cycle write strobe.
- `RBCP_RE` out 1: one-cycle read strobe.
- `RBCP_ACK` in 1: strobe completion.
- `RBCP_RD` in 8: read data, valid in the `RBCP_ACK` cycle.
- `TIMEOUT_ERR` out 1: sticky; set when an ACK wait expires.
- `FORMAT_ERR` out 1: sticky; set on a malformed or truncated packet.

## Operation
- Request header is 8 bytes:
  - b0: version, must be 0xFF.
  - b1: command, 0x80 = write, 0xC0 = read.
  - b2: ID.
  - b3: LEN, must be 1..255.
  - b4..b7: base address, big-endian.
  - Write requests follow the header with LEN data bytes. Read requests carry no data.
- States and transitions:
  - HDR: collect header bytes 0..7.
    - On a bad b0, a bad b1 or LEN=0: set FORMAT_ERR. Go to DROP, or to HDR if that byte had `RX_LAST`.
    - On `RX_LAST` before b7: set FORMAT_ERR and return to HDR. No reply is sent.
    - On a valid b7: go to TX_HDR.
  - DROP: discard bytes until `RX_LAST`, then HDR.
  - TX_HDR: emit the reply header: 0xFF, b1|0x08, ID, LEN, b4..b7. Then go to WR_RX (write) or RD_BUS (read).
  - WR_RX: accept one data byte, then WR_BUS.
  - WR_BUS: pulse `RBCP_WE`, then wait for ACK. Then WR_TX.
  - WR_TX: echo the written byte.
  - RD_BUS: pulse `RBCP_RE`, wait for ACK and capture `RBCP_RD`. Then RD_TX.
  - RD_TX: emit the captured byte.
  - Loop: after byte index i = LEN-1, go to DRAIN. Otherwise increment i and return to WR_RX or RD_BUS.
  - DRAIN: discard the remaining request bytes until `RX_LAST`. Go to HDR directly if `RX_LAST` has already been seen.
    - Extra write bytes or read payload bytes set FORMAT_ERR.
- Address rule: `RBCP_ADDR` = base + i, a 32-bit add that wraps 0xFFFFFFFF→0x00000000.
- Truncated write (`RX_LAST` on data byte i < LEN-1):
  - Byte i is written normally.
  - Remaining bytes are not written. Their reply bytes are 0x00.
  - FORMAT_ERR is set. The reply length stays 8+LEN.
- Timeout: no ACK within `ACK_TIMEOUT` cycles of the strobe.
  - Set TIMEOUT_ERR. The reply byte is 0x00 on reads and the echoed byte on writes.
  - Continue with the next index.
- `RBCP_ACT` is high from entering TX_HDR through the cycle after the last ACK or timeout. It is low otherwise.
- `RX_READY` is high only in HDR, DROP, WR_RX and DRAIN (DRAIN only while `RX_LAST` is still unseen).

## Timing
- While `BUS_RST` is high, and in the cycle after it, all outputs are 0: `RX_READY`, `TX_*`, all `RBCP_*` outputs, and both ERR flags.
  - State is HDR. `RX_READY`=1 from the second cycle after reset is released.
- Reset mid-packet aborts immediately: no reply, no further strobes.
- All outputs are registered.
- Strobes:
  - WE/RE is high for exactly one cycle. ADDR/WD are stable from the strobe cycle until the ACK cycle.
  - ACK is sampled from the cycle after the strobe.
  - An ACK coincident with the strobe is ignored.
- Write byte latency: byte accepted in cycle n → WE at n+1 → ACK (from `rbcp_to_bus`) at n+2 → `TX_VALID` at n+3.
- Read byte latency: RE at n, ACK at n+1, `TX_VALID` at n+2 with `TX_DATA` = `RBCP_RD` captured at n+1.
- `TX_DATA`/`TX_VALID`/`TX_LAST` hold until `TX_READY`. The next state is entered the cycle after the handshake.
- `TX_LAST` is high only on reply byte 8+LEN-1.
- Timeout: if no ACK arrives by strobe cycle + `ACK_TIMEOUT`, the wait ends in that cycle. A late ACK is ignored.

## Test plan
- Write: request FF 80 01 02 00 00 10 00, data AA 55, `RX_LAST` on 55.
  - Required: WE at addr 0x1000 with WD AA, then at 0x1001 with 55.
  - Reply is FF 88 01 02 00 00 10 00 AA 55, `TX_LAST` on 55. No ERR flags.
- Read: request FF C0 07 03 FF FF FF FF, `RBCP_RD` returns 11,22,33.
  - Required: RE at FFFFFFFF, 00000000, 00000001 (wrap).
  - Reply is FF C8 07 03 FF FF FF FF 11 22 33.
- Bad header: b0=FE, 5 bytes with `RX_LAST`.
  - Required: no strobes, no reply, FORMAT_ERR=1.
  - A following valid packet is still processed.
- Timeout: `ACK_TIMEOUT`=4, ACK held low on a 1-byte read.
  - Required: reply data 0x00 and TIMEOUT_ERR=1 exactly 4 cycles after RE.
- Backpressure and truncation: `TX_READY` toggled 1/0 while a write with LEN=3 ends after 1 data byte.
  - Required: exactly one WE, reply data AA 00 00 with no reply bytes lost or duplicated, FORMAT_ERR=1.
- Reset: `BUS_RST` asserted during the second strobe wait.
  - Required: all outputs 0 during reset, with `RX_READY`=1 on the second cycle after reset is released.
